arbiter_round_robin: RTL

// - Round-robin arbiter producing a registered one-hot grant vector from WIDTH request lines.
// - Sits directly upstream of the one-hot encoder.
//   - gnt is guaranteed one-hot or zero, so it feeds onehot_encoder_base without a priority tree.
// - Grant is offered on a valid/ready handshake and held stable until accepted.
//

---
 rtl/arbiter_pkg.sv | 21 ++
 rtl/onehot_encoder_base.sv | 30 +++
 rtl/arbiter_round_robin.sv | 91 +++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arbiter_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Upper bound on requester count supported by thermo_above_f.
  localparam int ARB_MAX_W = 64;

  function automatic logic [ARB_MAX_W-1:0] thermo_above_f(input logic [ARB_MAX_W-1:0] onehot);
    logic [ARB_MAX_W-1:0] mask;
    logic                 seen;
    mask = '0;
    seen = 1'b0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      mask[i] = seen;
      seen    = seen | onehot[i];
    end
    return mask;
  endfunction

endpackage

// File: rtl/onehot_encoder_base.sv
// One-hot to binary encoder; input must be one-hot or zero (zero encodes to 0).
module onehot_encoder_base #(
  parameter  int WIDTH          = 8,
  parameter  int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     onehot,
  output logic [WIDTH_LOG-1:0] idx
);

  generate
    if (IMPLEMENTATION == 0) begin : g_or_tree
      // OR of indices is exact because at most one bit is set.
      always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (onehot[i]) idx = idx | WIDTH_LOG'(i);
        end
      end
    end else begin : g_priority
      always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (onehot[i]) idx = WIDTH_LOG'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/arbiter_round_robin.sv
// Round-robin arbiter with registered one-hot grant on a valid/ready handshake.
// Define ARBITER_ROUND_ROBIN_IDX_EN to add the binary gnt_idx output.
module arbiter_round_robin
  import arbiter_pkg::*;
#(
  parameter  int WIDTH     = 8,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  output logic [WIDTH-1:0]     gnt,
  output logic                 gnt_vld,
  input  logic                 gnt_rdy
`ifdef ARBITER_ROUND_ROBIN_IDX_EN
  ,
  output logic [WIDTH_LOG-1:0] gnt_idx
`endif
);

  arb_state_t       state, state_nxt;
  logic [WIDTH-1:0] gnt_nxt;
  logic [WIDTH-1:0] last, last_nxt;

  // Lowest set bit strictly above l if any, otherwise lowest set bit overall.
  function automatic logic [WIDTH-1:0] pick_f(input logic [WIDTH-1:0] r,
                                              input logic [WIDTH-1:0] l);
    logic [ARB_MAX_W-1:0] above;
    logic [WIDTH-1:0]     masked;
    above  = thermo_above_f(ARB_MAX_W'(l));
    masked = r & above[WIDTH-1:0];
    if (|masked) return masked & (~masked + WIDTH'(1));
    return r & (~r + WIDTH'(1));
  endfunction

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (|req) begin
          gnt_nxt   = pick_f(req, last);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (gnt_rdy) begin
          last_nxt = gnt;
          // Current winner is excluded so it cannot win back-to-back.
          if (|(req & ~gnt)) begin
            gnt_nxt = pick_f(req & ~gnt, gnt);
          end else begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
    end
  end

  assign gnt_vld = (state == GRANT);

`ifdef ARBITER_ROUND_ROBIN_IDX_EN
  onehot_encoder_base #(
    .WIDTH          (WIDTH),
    .IMPLEMENTATION (0)
  ) u_idx_enc (
    .onehot (gnt),
    .idx    (gnt_idx)
  );
`endif

endmodule
